// File: rtl/morse_letter_sequencer.sv
// Morse key sequencer: times presses/releases, packs DOT/DASH symbols into a letter, hands letters off via valid/ready.
// Optional build macro MORSE_AUTO_GAP_EN: a long release (GAP_TICKS) ends a letter without sep.
module morse_letter_sequencer #(
  parameter int DASH_TICKS = 7,
  parameter int GAP_TICKS  = 15,
  parameter int MAX_SYM    = 5,
  parameter int CNT_W      = 8
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               key,
  input  logic               sep,
  output logic [1:0]         sym_type,
  output logic               sym_valid,
  output logic [MAX_SYM-1:0] code,
  output logic [2:0]         len,
  output logic               letter_valid,
  input  logic               letter_ready,
  output logic               overflow
);

  localparam logic [1:0] SYM_GAP  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_STOP = 2'b11;

`ifdef MORSE_AUTO_GAP_EN
  localparam bit AUTO_GAP = 1'b1;
`else
  localparam bit AUTO_GAP = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAPWAIT, ST_EMIT} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [MAX_SYM-1:0] code_reg;
  logic [2:0]         len_reg;
  logic [1:0]         sym_type_reg;
  logic               sym_valid_reg;
  logic               letter_valid_reg;
  logic               overflow_reg;

  logic [MAX_SYM-1:0] slot_mask;
  logic               is_dash;
  logic               buf_full;
  logic               auto_gap;

  // One-hot mask selecting the buffer slot for the next symbol
  genvar gi;
  generate
    for (gi = 0; gi < MAX_SYM; gi++) begin : g_slot
      assign slot_mask[gi] = (len_reg == 3'(gi));
    end
  endgenerate

  assign is_dash  = (cnt_reg >= CNT_W'(DASH_TICKS));
  assign buf_full = (len_reg >= 3'(MAX_SYM));
  assign auto_gap = AUTO_GAP && (cnt_reg >= CNT_W'(GAP_TICKS));
  assign cnt_next = (tick && (cnt_reg != '1)) ? cnt_reg + CNT_W'(1) : cnt_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      code_reg         <= '0;
      len_reg          <= '0;
      sym_type_reg     <= SYM_STOP;
      sym_valid_reg    <= 1'b0;
      letter_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      sym_valid_reg <= 1'b0;
      cnt_reg       <= cnt_next;
      case (state_reg)
        ST_IDLE: begin
          if (key) begin
            state_reg <= ST_PRESS;
            cnt_reg   <= '0;
          end
        end
        ST_PRESS: begin
          if (!key) begin
            state_reg     <= ST_GAPWAIT;
            cnt_reg       <= '0;
            sym_type_reg  <= is_dash ? SYM_DASH : SYM_DOT;
            sym_valid_reg <= 1'b1;
            // A full buffer still reports the symbol but drops it from the letter
            if (!buf_full) begin
              code_reg <= code_reg | (slot_mask & {MAX_SYM{is_dash}});
              len_reg  <= len_reg + 3'd1;
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
        ST_GAPWAIT: begin
          if (sep || auto_gap) begin
            state_reg        <= ST_EMIT;
            cnt_reg          <= '0;
            sym_type_reg     <= SYM_GAP;
            sym_valid_reg    <= 1'b1;
            letter_valid_reg <= 1'b1;
          end else if (key) begin
            state_reg <= ST_PRESS;
            cnt_reg   <= '0;
          end
        end
        ST_EMIT: begin
          if (letter_ready) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            letter_valid_reg <= 1'b0;
            code_reg         <= '0;
            len_reg          <= '0;
            overflow_reg     <= 1'b0;
            sym_type_reg     <= SYM_STOP;
            sym_valid_reg    <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign sym_type     = sym_type_reg;
  assign sym_valid    = sym_valid_reg;
  assign code         = code_reg;
  assign len          = len_reg;
  assign letter_valid = letter_valid_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Directed bench for morse_letter_sequencer; expected values are hand-computed per scenario.
module tb_morse_letter_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       key;
  logic       sep;
  logic [1:0] sym_type;
  logic       sym_valid;
  logic [4:0] code;
  logic [2:0] len;
  logic       letter_valid;
  logic       letter_ready;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  morse_letter_sequencer dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .tick         (tick),
    .key          (key),
    .sep          (sep),
    .sym_type     (sym_type),
    .sym_valid    (sym_valid),
    .code         (code),
    .len          (len),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .overflow     (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Press for n ticks (one tick per cycle) then release; returns just after the classification edge
  task automatic press(input int n);
    key  = 1'b1;
    tick = 1'b0;
    step();
    tick = 1'b1;
    repeat (n) step();
    key  = 1'b0;
    tick = 1'b0;
    step();
  endtask

  initial begin
    int  n;
    bit  saw_sym;
    bit  dropped;

    rst_n = 1'b0; key = 1'b0; sep = 1'b0; tick = 1'b0; letter_ready = 1'b0;
    step();
    step();
    check_value("rst_sym_type", 32'(sym_type), 32'h3);
    check_value("rst_sym_valid", 32'(sym_valid), 32'h0);
    check_value("rst_letter_valid", 32'(letter_valid), 32'h0);
    check_value("rst_overflow", 32'(overflow), 32'h0);
    check_value("rst_len", 32'(len), 32'h0);
    check_value("rst_code", 32'(code), 32'h0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-PRESS with one symbol already pending
    press(7);
    check_value("pre_rst_len", 32'(len), 32'h1);
    key = 1'b1; tick = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_value("midrst_len", 32'(len), 32'h0);
    check_value("midrst_code", 32'(code), 32'h0);
    check_value("midrst_sym_type", 32'(sym_type), 32'h3);
    check_value("midrst_letter_valid", 32'(letter_valid), 32'h0);
    key = 1'b0; tick = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // sep in IDLE with nothing pending does nothing
    sep = 1'b1;
    step();
    check_value("idle_sep_letter_valid", 32'(letter_valid), 32'h0);
    check_value("idle_sep_sym_valid", 32'(sym_valid), 32'h0);
    sep = 1'b0;
    step();

    // Dot/dash boundary
    press(6);
    check_value("p6_sym_type", 32'(sym_type), 32'h1);
    check_value("p6_sym_valid", 32'(sym_valid), 32'h1);
    check_value("p6_len", 32'(len), 32'h1);
    step();
    check_value("p6_pulse_end", 32'(sym_valid), 32'h0);
    press(7);
    check_value("p7_sym_type", 32'(sym_type), 32'h2);
    check_value("p7_code", 32'(code), 32'h02);
    letter_ready = 1'b1; sep = 1'b1;
    step();
    check_value("dd_letter_valid", 32'(letter_valid), 32'h1);
    check_value("dd_gap_type", 32'(sym_type), 32'h0);
    check_value("dd_gap_valid", 32'(sym_valid), 32'h1);
    check_value("dd_code", 32'(code), 32'h02);
    check_value("dd_len", 32'(len), 32'h2);
    sep = 1'b0;
    step();
    check_value("dd_hs_letter_valid", 32'(letter_valid), 32'h0);
    check_value("dd_stop_type", 32'(sym_type), 32'h3);
    check_value("dd_stop_valid", 32'(sym_valid), 32'h1);
    check_value("dd_hs_len", 32'(len), 32'h0);
    letter_ready = 1'b0;
    step();

    // Backpressure with letter K
    press(7);
    press(1);
    press(7);
    check_value("k_code", 32'(code), 32'h05);
    check_value("k_len", 32'(len), 32'h3);
    sep = 1'b1;
    step();
    check_value("k_letter_valid", 32'(letter_valid), 32'h1);
    sep = 1'b0;
    saw_sym = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key  = ~key;
      tick = 1'b1;
      step();
      if (sym_valid) saw_sym = 1'b1;
      if (!letter_valid) dropped = 1'b1;
    end
    key = 1'b0; tick = 1'b0;
    check_value("bp_no_sym", 32'(saw_sym), 32'h0);
    check_value("bp_valid_held", 32'(dropped), 32'h0);
    check_value("bp_code", 32'(code), 32'h05);
    check_value("bp_len", 32'(len), 32'h3);
    letter_ready = 1'b1;
    step();
    check_value("bp_hs_letter_valid", 32'(letter_valid), 32'h0);
    check_value("bp_stop_type", 32'(sym_type), 32'h3);
    letter_ready = 1'b0;
    sep = 1'b1;
    step();
    check_value("bp_idle_sep", 32'(letter_valid), 32'h0);
    sep = 1'b0;
    step();

    // Overflow: six dots, first with zero ticks held
    press(0);
    check_value("ov_zero_tick_dot", 32'(sym_type), 32'h1);
    for (int i = 0; i < 4; i++) press(1);
    check_value("ov_len5_no_flag", 32'(overflow), 32'h0);
    press(1);
    check_value("ov_flag", 32'(overflow), 32'h1);
    check_value("ov_sym_valid", 32'(sym_valid), 32'h1);
    check_value("ov_len", 32'(len), 32'h5);
    check_value("ov_code", 32'(code), 32'h00);
    letter_ready = 1'b1; sep = 1'b1;
    step();
    check_value("ov_emit_valid", 32'(letter_valid), 32'h1);
    check_value("ov_emit_flag", 32'(overflow), 32'h1);
    sep = 1'b0;
    step();
    check_value("ov_hs_flag", 32'(overflow), 32'h0);
    check_value("ov_hs_len", 32'(len), 32'h0);
    letter_ready = 1'b0;
    step();

    // key and sep together in GAPWAIT: sep wins, no new press
    press(1);
    key = 1'b1; sep = 1'b1;
    step();
    check_value("sim_letter_valid", 32'(letter_valid), 32'h1);
    check_value("sim_gap_type", 32'(sym_type), 32'h0);
    sep = 1'b0; tick = 1'b1;
    saw_sym = 1'b0;
    repeat (8) begin
      step();
      if (sym_valid) saw_sym = 1'b1;
    end
    key = 1'b0; tick = 1'b0;
    step();
    if (sym_valid) saw_sym = 1'b1;
    check_value("sim_no_press", 32'(saw_sym), 32'h0);
    check_value("sim_len", 32'(len), 32'h1);
    letter_ready = 1'b1;
    step();
    check_value("sim_hs", 32'(letter_valid), 32'h0);
    letter_ready = 1'b0;
    step();

    // Release gap timing
    press(1);
    tick = 1'b1;
    n = 0;
`ifdef MORSE_AUTO_GAP_EN
    while (!letter_valid && n < 40) begin
      step();
      n++;
    end
    check_value("ag_cycles", 32'(n), 32'd16);
    check_value("ag_letter_valid", 32'(letter_valid), 32'h1);
    check_value("ag_len", 32'(len), 32'h1);
`else
    while (!letter_valid && n < 100) begin
      step();
      n++;
    end
    check_value("noag_letter_valid", 32'(letter_valid), 32'h0);
    check_value("noag_len", 32'(len), 32'h1);
`endif
    tick = 1'b0;
    if (!letter_valid) begin
      sep = 1'b1;
      step();
      sep = 1'b0;
    end
    letter_ready = 1'b1;
    step();
    check_value("gap_final_hs", 32'(letter_valid), 32'h0);
    letter_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_letter_sequencer.md
Name: morse_letter_sequencer

Overview:
- Controller that sequences the Morse key datapath: times key presses and releases, classifies each press as DOT or DASH, and packs symbols into a letter buffer.
- Hands each completed letter to the downstream decoder over a valid/ready handshake.
- Sits between the board switches (key, letter separator) and the letter decode/display logic.
- Also reports each symbol on the 2-bit GAP/DOT/DASH/STOP type code.

Parameters:
- DASH_TICKS, 7: a press held for at least this many ticks is a DASH; shorter presses are a DOT (press of 1..6 ticks = DOT).
- GAP_TICKS, 15: release length that auto-terminates a letter (only with AUTO_GAP_EN).
- MAX_SYM, 5: maximum symbols per letter.
- CNT_W, 8: duration counter width; the counter saturates at all-ones.

Ports:
- clk_in  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  timing strobe, one clk_in cycle wide; durations are counted in ticks
- key  in  1  Morse key switch, synchronous, high = pressed
- sep  in  1  manual letter-separator switch, level, high = end letter
- sym_type  out  2  last symbol: 00 GAP, 01 DOT, 10 DASH, 11 STOP
- sym_valid  out  1  one-cycle pulse when sym_type updates
- code  out  MAX_SYM  letter symbols; bit i = symbol i (first symbol in bit 0), 1 = DASH; unused bits 0
- len  out  3  number of symbols in code (0..MAX_SYM)
- letter_valid  out  1  letter available; held until accepted
- letter_ready  in  1  downstream accepts the letter when letter_valid && letter_ready
- overflow  out  1  sticky flag; set if a symbol is dropped because the buffer is full; cleared on handshake

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, counter = 0, shift buffer = 0, len = 0, code = 0
  - sym_type = STOP, sym_valid = 0, letter_valid = 0, overflow = 0
- Counter:
  - Clears on every state change.
  - Increments on tick; saturates at 2^CNT_W-1.
- IDLE (no symbols pending):
  - key = 1 -> PRESS.
  - sep = 1 with len = 0 -> no action.
- PRESS:
  - Count ticks while key = 1.
  - On key = 0: classify (count >= DASH_TICKS -> DASH, else DOT), including count = 0.
  - Classification cycle:
    - If len < MAX_SYM: write symbol bit at index len and increment len.
    - Otherwise: drop the symbol and set overflow.
    - sym_type = class, sym_valid = 1 for one cycle.
    - Next state: GAPWAIT.
- GAPWAIT (letter in progress, key released):
  - Count ticks.
  - key = 1 -> PRESS.
  - sep = 1 -> EMIT with sym_type = GAP, sym_valid pulse.
  - key and sep both high in the same cycle: sep wins.
- EMIT:
  - Drive code/len from the buffer and assert letter_valid.
  - Hold code/len/letter_valid stable until the handshake.
  - key and sep are ignored while in EMIT.
  - Handshake cycle:
    - letter_valid = 0; buffer, len and overflow clear.
    - sym_type = STOP, sym_valid pulse.
    - Next state: IDLE.
- Latency: release-to-sym_valid = 1 cycle; sep-to-letter_valid = 1 cycle.
- letter_ready high while letter_valid is low has no effect.
- Reset mid-letter discards all pending symbols; no partial letter is emitted.

Optional Feature:
- Macro: MORSE_AUTO_GAP_EN.
- Defined:
  - In GAPWAIT, when count reaches GAP_TICKS, enter EMIT exactly as for sep (GAP sym_valid pulse).
  - sep still works and takes priority on the same cycle.
- Undefined:
  - Only sep terminates a letter; GAP_TICKS is unused.
  - GAPWAIT waits indefinitely.

Test Plan:
- Reset: rst_n low mid-PRESS -> all outputs at reset values immediately; after release, state = IDLE.
- Dot/dash boundary: press 6 ticks -> sym_type = 01; press 7 ticks -> sym_type = 10. Then sep with letter_ready = 1 -> code = 00010, len = 2, single-cycle letter_valid, then sym_type = 11.
- Backpressure: letter "K" (dash dot dash), sep, letter_ready = 0 for 20 cycles with key toggling -> code = 00101, len = 3, letter_valid held, no new symbols; ready = 1 -> accepted and state = IDLE.
- Overflow: 6 dots then sep -> len = 5, code = 00000, overflow = 1; after handshake overflow = 0.
- Auto gap (MORSE_AUTO_GAP_EN): dot, then idle 15 ticks -> letter_valid with len = 1. Without the macro the same stimulus gives no letter_valid after 100 ticks.
- Simultaneous events: key and sep rise together in GAPWAIT -> EMIT taken, no new PRESS; sep in IDLE with len = 0 -> no letter_valid.
